pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
- Downstream consumer of the UART pixel assembler's 24-bit data/valid pulse stream.
- Buffers pixels in a small show-ahead FIFO and tracks raster x/y across a FRAME_W x FRAME_H frame.
- Writes each pixel as one 32-bit word into the frame buffer through an Avalon-MM master write port.
- Signals frame completion and input overflow to the display/control logic.

Parameters:
- FRAME_W, 640, pixels per line
- FRAME_H, 480, lines per frame
- LINE_STRIDE, 1024, words between line starts (must be ≥ FRAME_W)
- BASE_ADDR, 0, byte address of pixel (0,0)
- ADDR_W, 32, avm_address width
- FIFO_DEPTH, 8, pixel FIFO entries (power of 2, ≥ 2)

Ports:
- avm_clk  in  1  block clock (single clock domain)
- avm_rst  in  1  asynchronous, active-high reset
- i_data  in  24  pixel {R,G,B}
- i_valid  in  1  one-cycle pixel strobe; no backpressure available upstream
- i_restart  in  1  synchronous pulse: flush FIFO, return to (0,0), clear overflow
- avm_address  out  ADDR_W  byte address of current write
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  {8'h00, pixel}
- avm_waitrequest  in  1  slave stall
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
- o_overflow  out  1  sticky: a pixel was dropped
- o_busy  out  1  FIFO non-empty or write outstanding

Behaviour:
- Reset (async, avm_rst=1):
  - FIFO empty; x=0, y=0; state S_IDLE.
  - avm_write=0, avm_address=BASE_ADDR, avm_writedata=0.
  - o_frame_done=0, o_overflow=0, o_busy=0.
- Push: i_valid sampled on each rising edge.
  - If registered count < FIFO_DEPTH, the pixel is written.
  - Otherwise it is dropped and o_overflow is set, even if a pop occurs on the same edge.
  - A simultaneous push and pop keeps the count unchanged.
- Address: BASE_ADDR + ((y*LINE_STRIDE + x) << 2), computed from registered x/y, ADDR_W-bit modulo arithmetic.
- FSM states:
  - S_IDLE: avm_write=0. When the FIFO is non-empty, register avm_write=1 with the head pixel and current address, then go to S_WRITE.
  - S_WRITE: hold avm_write/address/data stable while avm_waitrequest=1.
  - S_WRITE acceptance (avm_waitrequest=0): pop the FIFO and advance x/y.
    - If the FIFO still holds another entry, load it with the next address and stay in S_WRITE (back-to-back, 1 pixel/cycle).
    - Otherwise deassert avm_write and go to S_IDLE.
- Latency: a pixel with i_valid in cycle N (empty FIFO, S_IDLE) gives avm_write=1 in cycle N+2.
- Counter wrap:
  - x increments per accepted write.
  - At x=FRAME_W-1: x←0, y←y+1.
  - At (FRAME_W-1, FRAME_H-1): x←0, y←0 and o_frame_done pulses in the next cycle.
  - Frames repeat indefinitely.
- i_restart: FIFO flushed, x/y←0, o_overflow←0 on the next edge.
  - If avm_write is high and not yet accepted, it is held until accepted (Avalon rule).
  - That accepted write does not advance x/y and raises no frame_done; the FSM then returns to S_IDLE.
  - An i_valid in the same cycle as i_restart is discarded.
- avm_writedata[31:24] is always 0.
- o_busy = (count≠0) | avm_write.

Decomposition:
- Package pfw_pkg:
  - state enum {S_IDLE, S_WRITE}
  - pixel_t (24-bit)
  - WORD_BYTES=4 shift constant
- Sub-module pfw_pixel_fifo:
  - synchronous show-ahead FIFO, parameter DEPTH/WIDTH
  - ports push, pop, flush, din, dout, count, full, empty
  - same avm_clk/avm_rst

Test Plan:
- FRAME_W=4, FRAME_H=2, LINE_STRIDE=8, BASE_ADDR=0x1000, waitrequest=0; 8 single pixels 0x000001..0x000008 spaced 3 cycles -> writes at 0x1000,0x1004,0x1008,0x100C,0x1020,0x1024,0x1028,0x102C with data 0x00000001..0x00000008; o_frame_done pulses once, the cycle after the 8th accept.
- Latency: one pixel 0xABCDEF at cycle N -> avm_write=1 at N+2 with avm_writedata=0x00ABCDEF; dropped after 1 cycle.
- Backpressure: waitrequest held high 5 cycles during first write while 3 more pixels arrive -> address/data stable throughout; then 4 accepted back-to-back on consecutive cycles; no overflow.
- Overflow: FIFO_DEPTH=8, waitrequest held high, 12 consecutive valids -> the write in flight plus the 8 FIFO entries are all written after release; 3 pixels dropped; o_overflow=1 and remains 1.
- Restart mid-write: waitrequest high, 3 pixels queued, i_restart pulsed -> current write held then accepted, FIFO empty, o_overflow=0; next pixel written at 0x1000.
- Async reset asserted mid-S_WRITE -> avm_write=0, o_busy=0 immediately without a clock edge; after release the first pixel goes to 0x1000.

Source files
------------

// File: rtl/pfw_pkg.sv
// Shared types and constants for the pixel frame writer.
package pfw_pkg;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    typedef logic [23:0] pixel_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

endpackage

// File: rtl/pixel_frame_writer_if.sv
// Avalon-MM write-only master bundle between the pixel writer and the frame buffer.
interface pixel_frame_writer_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest
    );

endinterface

// File: rtl/pfw_pixel_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the head entry while not empty.
module pfw_pixel_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     avm_clk,
    input  logic                     avm_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge avm_clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pixel_frame_writer.sv
// Buffers incoming pixels and writes them as 32-bit words into a raster frame buffer
// over Avalon-MM, tracking x/y position and reporting frame completion and overflow.
module pixel_frame_writer
    import pfw_pkg::*;
#(
    parameter int unsigned       FRAME_W     = 640,
    parameter int unsigned       FRAME_H     = 480,
    parameter int unsigned       LINE_STRIDE = 1024,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       FIFO_DEPTH  = 8
) (
    input  logic                 avm_clk,
    input  logic                 avm_rst,
    input  pixel_t               i_data,
    input  logic                 i_valid,
    input  logic                 i_restart,
    pixel_frame_writer_if.master avm,
    output logic                 o_frame_done,
    output logic                 o_overflow,
    output logic                 o_busy
);

    localparam int unsigned XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int unsigned YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    state_t                   state_q, state_d;
    logic [XW-1:0]            x_q, x_d, nx;
    logic [YW-1:0]            y_q, y_d, ny;
    logic                     wrap;
    logic                     write_q, write_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [31:0]              data_q, data_d;
    logic                     pend_q, pend_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    pixel_t                   fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    function automatic logic [ADDR_W-1:0] pix_addr(logic [XW-1:0] x, logic [YW-1:0] y);
        logic [ADDR_W-1:0] word;
        word = ADDR_W'(y) * ADDR_W'(LINE_STRIDE) + ADDR_W'(x);
        return BASE_ADDR + (word << WORD_SHIFT);
    endfunction

    // A pixel arriving alongside restart belongs to the abandoned frame.
    assign fifo_push = i_valid & ~i_restart & ~fifo_full;

    pfw_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pixel_t))
    ) u_fifo (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (i_restart),
        .din     (i_data),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        write_d  = write_q;
        addr_d   = addr_q;
        data_d   = data_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        nx       = x_q + XW'(1);
        ny       = y_q;
        wrap     = 1'b0;

        if (x_q == XW'(FRAME_W - 1)) begin
            nx = '0;
            if (y_q == YW'(FRAME_H - 1)) begin
                ny   = '0;
                wrap = 1'b1;
            end else begin
                ny = y_q + YW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !i_restart) begin
                    fifo_pop = 1'b1;
                    write_d  = 1'b1;
                    addr_d   = pix_addr(x_q, y_q);
                    data_d   = {8'h00, fifo_dout};
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!avm.avm_waitrequest) begin
                    // A write held across a restart completes without moving the raster.
                    if (pend_q || i_restart) begin
                        write_d = 1'b0;
                        pend_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        x_d    = nx;
                        y_d    = ny;
                        done_d = wrap;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            addr_d   = pix_addr(nx, ny);
                            data_d   = {8'h00, fifo_dout};
                        end else begin
                            write_d = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end else if (i_restart) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_restart) begin
            x_d = '0;
            y_d = '0;
        end
    end

    // Overflow is judged on the registered count, so a same-edge pop does not save the pixel.
    assign ovf_d = i_restart ? 1'b0 : (ovf_q | (i_valid & fifo_full));

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            write_q <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign avm.avm_write     = write_q;
    assign avm.avm_address   = addr_q;
    assign avm.avm_writedata = data_q;
    assign o_frame_done      = done_q;
    assign o_overflow        = ovf_q;
    assign o_busy            = (fifo_count != '0) | write_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer on a 4x2 frame with stride 8 at base 0x1000.
module tb_pixel_frame_writer;

    localparam int unsigned FW = 4;
    localparam int unsigned FH = 2;
    localparam int unsigned LS = 8;
    localparam int unsigned FD = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        restart = 1'b0;
    logic [23:0] data = '0;
    logic        done, ovf, busy;

    pixel_frame_writer_if #(.ADDR_W(32)) avm_bus ();

    pixel_frame_writer #(
        .FRAME_W     (FW),
        .FRAME_H     (FH),
        .LINE_STRIDE (LS),
        .ADDR_W      (32),
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (FD)
    ) dut (
        .avm_clk      (clk),
        .avm_rst      (rst),
        .i_data       (data),
        .i_valid      (valid),
        .i_restart    (restart),
        .avm          (avm_bus),
        .o_frame_done (done),
        .o_overflow   (ovf),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [23:0] pix;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    wr_t wq[$];
    int  done_cnt = 0;
    int  done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted write and every frame_done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (avm_bus.avm_write && !avm_bus.avm_waitrequest)
                wq.push_back('{avm_bus.avm_address, avm_bus.avm_writedata, cyc});
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [31:0] ea,
                          input logic [31:0] ed);
        if (idx >= wq.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: write %0d missing, only %0d seen, expected addr 0x%08h",
                     name, idx, wq.size(), ea);
        end else begin
            chk({name, "_addr"}, wq[idx].addr, ea);
            chk({name, "_data"}, wq[idx].wdata, ed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input string name, input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (wq.size() >= target) break;
            tick();
        end
        chk(name, 32'(wq.size() >= target), 32'd1);
    endtask

    vec_t        vt[8];
    logic [31:0] fr_addr [8] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                 32'h1020, 32'h1024, 32'h1028, 32'h102C};
    logic [31:0] bp_addr [4] = '{32'h1004, 32'h1008, 32'h100C, 32'h1020};
    logic [31:0] ov_addr [9] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                 32'h1020, 32'h1024, 32'h1028, 32'h102C, 32'h1000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int d0;

        for (int i = 0; i < 8; i++) begin
            vt[i].pix   = 24'(i + 1);
            vt[i].addr  = fr_addr[i];
            vt[i].wdata = 32'(i + 1);
        end
        avm_bus.avm_waitrequest = 1'b0;

        // Reset state
        #12;
        chk("rst_write", 32'(avm_bus.avm_write), 32'd0);
        chk("rst_addr", avm_bus.avm_address, BASE);
        chk("rst_wdata", avm_bus.avm_writedata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Full frame from the vector table, one pixel every 3 cycles
        base = wq.size();
        d0   = done_cnt;
        for (int i = 0; i < 8; i++) begin
            data  = vt[i].pix;
            valid = 1'b1;
            tick();
            valid = 1'b0;
            tick();
            tick();
        end
        wait_writes("frame_writes", base + 8, 20);
        tick();
        tick();
        for (int i = 0; i < 8; i++)
            chk_wr($sformatf("frame_wr%0d", i), base + i, vt[i].addr, vt[i].wdata);
        chk("frame_done_count", 32'(done_cnt - d0), 32'd1);
        if (wq.size() >= base + 8)
            chk("frame_done_cycle", 32'(done_cyc), 32'(wq[base + 7].cyc + 1));

        // Latency: valid in cycle N, write in N+2, gone in N+3
        data  = 24'hABCDEF;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("lat_n1_write", 32'(avm_bus.avm_write), 32'd0);
        tick();
        chk("lat_n2_write", 32'(avm_bus.avm_write), 32'd1);
        chk("lat_n2_data", avm_bus.avm_writedata, 32'h00AB_CDEF);
        chk("lat_n2_addr", avm_bus.avm_address, 32'h1000);
        tick();
        chk("lat_n3_write", 32'(avm_bus.avm_write), 32'd0);
        tick();

        // Backpressure: first write stalled while 3 more pixels queue up
        base = wq.size();
        d0   = done_cnt;
        avm_bus.avm_waitrequest = 1'b1;
        for (int k = 0; k < 7; k++) begin
            valid = (k < 4);
            data  = 24'h110000 + 24'(k);
            tick();
            if (k >= 1) begin
                chk($sformatf("bp_hold_write%0d", k), 32'(avm_bus.avm_write), 32'd1);
                chk($sformatf("bp_hold_addr%0d", k), avm_bus.avm_address, 32'h1004);
                chk($sformatf("bp_hold_data%0d", k), avm_bus.avm_writedata, 32'h0011_0000);
            end
        end
        valid = 1'b0;
        avm_bus.avm_waitrequest = 1'b0;
        wait_writes("bp_writes", base + 4, 12);
        tick();
        for (int i = 0; i < 4; i++)
            chk_wr($sformatf("bp_wr%0d", i), base + i, bp_addr[i], 32'h0011_0000 + 32'(i));
        if (wq.size() >= base + 4)
            for (int i = 1; i < 4; i++)
                chk($sformatf("bp_b2b%0d", i), 32'(wq[base + i].cyc - wq[base + i - 1].cyc),
                    32'd1);
        chk("bp_ovf", 32'(ovf), 32'd0);
        chk("bp_no_done", 32'(done_cnt - d0), 32'd0);
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // Idle restart returns the raster to (0,0)
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();

        // Overflow: 12 back-to-back pixels against a stalled slave
        base = wq.size();
        d0   = done_cnt;
        avm_bus.avm_waitrequest = 1'b1;
        for (int k = 0; k < 12; k++) begin
            valid = 1'b1;
            data  = 24'h220000 + 24'(k);
            tick();
        end
        valid = 1'b0;
        tick();
        tick();
        chk("ov_flag", 32'(ovf), 32'd1);
        chk("ov_inflight_addr", avm_bus.avm_address, 32'h1000);
        chk("ov_inflight_data", avm_bus.avm_writedata, 32'h0022_0000);
        avm_bus.avm_waitrequest = 1'b0;
        wait_writes("ov_writes", base + 9, 20);
        tick();
        tick();
        tick();
        chk("ov_write_count", 32'(wq.size() - base), 32'd9);
        for (int i = 0; i < 9; i++)
            chk_wr($sformatf("ov_wr%0d", i), base + i, ov_addr[i], 32'h0022_0000 + 32'(i));
        chk("ov_sticky", 32'(ovf), 32'd1);
        chk("ov_done_count", 32'(done_cnt - d0), 32'd1);
        chk("ov_busy", 32'(busy), 32'd0);

        // Restart while a write is stalled, with a same-cycle pixel that must be discarded
        base = wq.size();
        d0   = done_cnt;
        avm_bus.avm_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            valid = 1'b1;
            data  = 24'h330000 + 24'(k);
            tick();
        end
        valid   = 1'b0;
        tick();
        restart = 1'b1;
        valid   = 1'b1;
        data    = 24'h3AAAAA;
        tick();
        restart = 1'b0;
        valid   = 1'b0;
        chk("rs_hold_write", 32'(avm_bus.avm_write), 32'd1);
        chk("rs_hold_addr", avm_bus.avm_address, 32'h1004);
        chk("rs_hold_data", avm_bus.avm_writedata, 32'h0033_0000);
        chk("rs_ovf_clear", 32'(ovf), 32'd0);
        tick();
        chk("rs_hold_write2", 32'(avm_bus.avm_write), 32'd1);
        avm_bus.avm_waitrequest = 1'b0;
        tick();
        chk("rs_after_write", 32'(avm_bus.avm_write), 32'd0);
        chk("rs_after_busy", 32'(busy), 32'd0);
        chk("rs_write_count", 32'(wq.size() - base), 32'd1);
        chk_wr("rs_wr", base, 32'h1004, 32'h0033_0000);
        data  = 24'h3BBBBB;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("rs_next_write", 32'(avm_bus.avm_write), 32'd1);
        chk("rs_next_addr", avm_bus.avm_address, 32'h1000);
        chk("rs_next_data", avm_bus.avm_writedata, 32'h003B_BBBB);
        tick();
        chk("rs_no_done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset in the middle of a stalled write
        avm_bus.avm_waitrequest = 1'b1;
        data  = 24'h440000;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("ar_pre_write", 32'(avm_bus.avm_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_write", 32'(avm_bus.avm_write), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_addr", avm_bus.avm_address, BASE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        avm_bus.avm_waitrequest = 1'b0;
        tick();
        data  = 24'h440001;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("ar_next_write", 32'(avm_bus.avm_write), 32'd1);
        chk("ar_next_addr", avm_bus.avm_address, 32'h1000);
        chk("ar_next_data", avm_bus.avm_writedata, 32'h0044_0001);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
